// File: rtl/video_pixel_shifter_pkg.sv
// Shared constants for the video output path.
package video_pixel_shifter_pkg;

    // Framebuffer word width at the default configuration.
    localparam int unsigned VIDEO_WORD_W = 16;

    // A set framebuffer bit is black.
    localparam logic BLACK_BIT = 1'b1;

    // Word shown when the prefetch buffer runs dry: all black.
    localparam logic [VIDEO_WORD_W-1:0] BLANK_FILL = {VIDEO_WORD_W{BLACK_BIT}};

endpackage

// File: rtl/video_word_fifo.sv
// Two-entry prefetch FIFO: valid/ready on the write side, pop/empty on the read side.
// A word written into an empty FIFO is only poppable from the following cycle.
module video_word_fifo #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push;
    logic             do_pop;

    assign wr_ready = (count_q != 2'd2);
    assign empty    = (count_q == 2'd0);
    assign push     = wr_valid & wr_ready;
    assign do_pop   = pop & ~empty;
    assign rd_data  = mem_q[rd_ptr_q];

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Storage needs no reset; the count guards against reading stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/video_pixel_shifter.sv
// Serialises framebuffer words into a 1-bit pixel stream and delays sync/blank to match.
module video_pixel_shifter
    import video_pixel_shifter_pkg::*;
#(
    parameter int unsigned WORD_W     = VIDEO_WORD_W,
    parameter int unsigned SYNC_DELAY = 4,
    parameter int unsigned UNDERRUN_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  load_pixels,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblank_n,
    input  logic                  vblank_n,
    input  logic                  wr_valid,
    input  logic [WORD_W-1:0]     wr_data,
    output logic                  wr_ready,
    input  logic                  invert,
    output logic                  pixel,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  blank_n_out,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    localparam logic [WORD_W-1:0] FILL = {WORD_W{BLACK_BIT}};

    logic                  load;
    logic                  fifo_empty;
    logic [WORD_W-1:0]     fifo_data;
    logic [WORD_W-1:0]     sr_q;
    logic [WORD_W-1:0]     sr_d;
    logic [UNDERRUN_W-1:0] underrun_q;
    logic [SYNC_DELAY-1:0] hs_q;
    logic [SYNC_DELAY-1:0] vs_q;
    logic [SYNC_DELAY-1:0] bl_q;
    logic                  pixel_q;
    logic                  pixel_d;

    assign load = clk_en & load_pixels;

    video_word_fifo #(
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .pop      (load),
        .rd_data  (fifo_data),
        .empty    (fifo_empty)
    );

    // Shift register next state: load head word (or black on underrun), else shift in black.
    always_comb begin
        sr_d = {sr_q[WORD_W-2:0], BLACK_BIT};
        if (load) begin
            sr_d = fifo_empty ? FILL : fifo_data;
        end
    end

    // Pixel next state. Gating with the stage before the blank output makes the registered
    // pixel and blank_n_out change on the same edge.
    always_comb begin
        pixel_d = 1'b0;
        if (bl_q[SYNC_DELAY-2]) begin
            pixel_d = (sr_q[WORD_W-1] != BLACK_BIT) ^ invert;
        end
    end

    // Shift register, underrun counter and pixel register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q       <= '0;
            underrun_q <= '0;
            pixel_q    <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            pixel_q <= pixel_d;
            if (load && fifo_empty && (underrun_q != {UNDERRUN_W{1'b1}})) begin
                underrun_q <= underrun_q + 1'b1;
            end
        end
    end

    // Sync/blank delay lines run every clk, independent of clk_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q <= '1;
            vs_q <= '1;
            bl_q <= '0;
        end else begin
            hs_q <= {hs_q[SYNC_DELAY-2:0], hsync_in};
            vs_q <= {vs_q[SYNC_DELAY-2:0], vsync_in};
            bl_q <= {bl_q[SYNC_DELAY-2:0], hblank_n & vblank_n};
        end
    end

    assign pixel        = pixel_q;
    assign hsync_out    = hs_q[SYNC_DELAY-1];
    assign vsync_out    = vs_q[SYNC_DELAY-1];
    assign blank_n_out  = bl_q[SYNC_DELAY-1];
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_video_pixel_shifter.sv
// Directed bench for video_pixel_shifter.
module tb_video_pixel_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        load_pixels;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblank_n;
    logic        vblank_n;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        invert;
    logic        pixel;
    logic        hsync_out;
    logic        vsync_out;
    logic        blank_n_out;
    logic [7:0]  underrun_cnt;

    int checks = 0;
    int errors = 0;

    video_pixel_shifter #(
        .WORD_W     (16),
        .SYNC_DELAY (4),
        .UNDERRUN_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .load_pixels  (load_pixels),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .hblank_n     (hblank_n),
        .vblank_n     (vblank_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .invert       (invert),
        .pixel        (pixel),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .blank_n_out  (blank_n_out),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic load();
        clk_en      = 1'b1;
        load_pixels = 1'b1;
        tick();
        clk_en      = 1'b0;
        load_pixels = 1'b0;
    endtask

    // Collect the 16 pixels that follow a load, first pixel in bit 15.
    task automatic grab(output logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            tick();
            v[15-i] = pixel;
        end
    endtask

    initial begin
        logic [15:0] v;
        int first_low;
        int low_cnt;

        reset       = 1'b1;
        clk_en      = 1'b0;
        load_pixels = 1'b0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        hblank_n    = 1'b0;
        vblank_n    = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = 16'h0;
        invert      = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;

        // Reset release: idle outputs for the first 4 clk.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_hsync", hsync_out, 1);
            chk("rst_vsync", vsync_out, 1);
            chk("rst_blank", blank_n_out, 0);
            chk("rst_pixel", pixel, 0);
            chk("rst_ready", wr_ready, 1);
            chk("rst_underrun", underrun_cnt, 0);
        end

        // Unblank: blank_n_out rises exactly 4 clk later.
        hblank_n = 1'b1;
        vblank_n = 1'b1;
        tick();
        tick();
        tick();
        chk("blank_delay_3", blank_n_out, 0);
        tick();
        chk("blank_delay_4", blank_n_out, 1);

        // 0xF0F0 -> 0000 1111 0000 1111, then black fill.
        push(16'hF0F0);
        load();
        grab(v);
        chk("f0f0_pixels", v, 16'h0F0F);
        tick();
        chk("fill_black", pixel, 0);

        // Same with inversion.
        invert = 1'b1;
        push(16'hF0F0);
        load();
        grab(v);
        chk("f0f0_invert", v, 16'hF0F0);
        invert = 1'b0;

        // Three back-to-back pushes: third is dropped.
        wr_valid = 1'b1;
        wr_data  = 16'hC3A5;
        chk("ready_w1", wr_ready, 1);
        tick();
        wr_data = 16'h5A3C;
        chk("ready_w2", wr_ready, 1);
        tick();
        wr_data = 16'hAAAA;
        chk("ready_w3", wr_ready, 0);
        tick();
        wr_valid = 1'b0;
        load();
        grab(v);
        chk("word1", v, 16'h3C5A);
        load();
        grab(v);
        chk("word2", v, 16'hA5C3);
        load();
        chk("underrun_1", underrun_cnt, 1);
        grab(v);
        chk("underrun_black", v, 16'h0000);

        // Load every clk with an empty buffer: saturate at 255.
        clk_en      = 1'b1;
        load_pixels = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 10) chk("underrun_pixel", pixel, 0);
            if (i == 253) chk("underrun_254", underrun_cnt, 254);
        end
        clk_en      = 1'b0;
        load_pixels = 1'b0;
        chk("underrun_sat", underrun_cnt, 255);

        // Push and load in the same cycle at count=1.
        push(16'h8001);
        wr_valid    = 1'b1;
        wr_data     = 16'h7FFE;
        clk_en      = 1'b1;
        load_pixels = 1'b1;
        tick();
        wr_valid    = 1'b0;
        clk_en      = 1'b0;
        load_pixels = 1'b0;
        chk("pushpop_ready", wr_ready, 1);
        grab(v);
        chk("pushpop_old", v, 16'h7FFE);
        load();
        grab(v);
        chk("pushpop_new", v, 16'h8001);
        load();
        grab(v);
        chk("pushpop_empty", v, 16'h0000);

        // Push into empty FIFO while loading: no bypass.
        wr_valid    = 1'b1;
        wr_data     = 16'h00FF;
        clk_en      = 1'b1;
        load_pixels = 1'b1;
        tick();
        wr_valid    = 1'b0;
        clk_en      = 1'b0;
        load_pixels = 1'b0;
        grab(v);
        chk("nobypass_black", v, 16'h0000);
        load();
        grab(v);
        chk("nobypass_word", v, 16'hFF00);

        // load_pixels without clk_en must not pop.
        push(16'h0000);
        load_pixels = 1'b1;
        tick();
        load_pixels = 1'b0;
        load();
        grab(v);
        chk("clk_en_gate", v, 16'hFFFF);

        // hsync pulse of 68 clk delayed by 4.
        first_low = -1;
        low_cnt   = 0;
        hsync_in  = 1'b0;
        for (int i = 1; i <= 90; i++) begin
            tick();
            if (hsync_out == 1'b0) begin
                if (first_low < 0) first_low = i;
                low_cnt++;
            end
            if (i == 68) hsync_in = 1'b1;
        end
        chk("hsync_delay", first_low, 4);
        chk("hsync_width", low_cnt, 68);
        chk("vsync_idle", vsync_out, 1);

        // Blanking forces pixel to 0 even when inverted black would be 1.
        invert   = 1'b1;
        hblank_n = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("blank_forces_0", pixel, 0);
        hblank_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("unblank_invert", pixel, 1);
        invert = 1'b0;

        // Reset mid-line.
        push(16'h0000);
        load();
        tick();
        tick();
        chk("pre_reset_pixel", pixel, 1);
        push(16'h1111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_pixel", pixel, 0);
        chk("midrst_ready", wr_ready, 1);
        chk("midrst_blank", blank_n_out, 0);
        chk("midrst_underrun", underrun_cnt, 0);
        push(16'h1234);
        chk("midrst_fifo_1", wr_ready, 1);
        push(16'h5678);
        chk("midrst_fifo_2", wr_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
